// File: rtl/mult_div_unit_pkg.sv
// Shared MDU opcodes, move-from select encodings and controller state type.
package mult_div_unit_pkg;

   localparam logic [3:0] MDU_DUM   = 4'd0;
   localparam logic [3:0] MDU_MULT  = 4'd1;
   localparam logic [3:0] MDU_MULTU = 4'd2;
   localparam logic [3:0] MDU_DIV   = 4'd3;
   localparam logic [3:0] MDU_DIVU  = 4'd4;
   localparam logic [3:0] MDU_MTHI  = 4'd5;
   localparam logic [3:0] MDU_MTLO  = 4'd6;

   localparam logic [1:0] MF_NONE = 2'b00;
   localparam logic [1:0] MF_HI   = 2'b01;
   localparam logic [1:0] MF_LO   = 2'b10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } mdu_state_e;

endpackage

// File: rtl/mult_div_unit.sv
// Multiply/divide unit: result computed at accept into shadow registers,
// committed to HI/LO after a fixed multi-cycle latency held by a down-counter.
//
// state   | meaning
// ST_IDLE | counter = 0, may accept MULT/DIV or MTHI/MTLO
// ST_RUN  | counter > 0, busy; commits shadow to HI/LO when counter hits 1
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        clr,
   input  logic [1:0]  mf_sel,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] mf_result
);

   localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(CNT_MAX + 1);

   mdu_state_e    r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [31:0]   r_hi, r_lo, r_sh_hi, r_sh_lo;
   logic          w_commit, w_issue, w_is_mul, w_is_div, w_accept, w_mthi, w_mtlo;

   logic [63:0] w_prod_s, w_prod_u, w_res;
   logic [31:0] w_a_mag, w_b_mag, w_b_mag_nz, w_b_nz;
   logic [31:0] w_sq, w_sr, w_uq, w_ur, w_q_s, w_r_s;

   assign w_issue  = start && !busy && !clr;
   assign w_is_mul = (op == MDU_MULT) || (op == MDU_MULTU);
   assign w_is_div = (op == MDU_DIV) || (op == MDU_DIVU);
   assign w_accept = w_issue && (w_is_mul || w_is_div);
   assign w_mthi   = w_issue && (op == MDU_MTHI);
   assign w_mtlo   = w_issue && (op == MDU_MTLO);

   assign w_prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
   assign w_prod_u = {32'd0, a} * {32'd0, b};

   // Signed divide on magnitudes; 0x80000000/-1 falls out as 0x80000000 rem 0.
   // Zero divisors are replaced by 1 only to keep the dividers X-free.
   assign w_a_mag    = a[31] ? (32'd0 - a) : a;
   assign w_b_mag    = b[31] ? (32'd0 - b) : b;
   assign w_b_mag_nz = (b == 32'd0) ? 32'd1 : w_b_mag;
   assign w_b_nz     = (b == 32'd0) ? 32'd1 : b;
   assign w_sq       = w_a_mag / w_b_mag_nz;
   assign w_sr       = w_a_mag % w_b_mag_nz;
   assign w_uq       = a / w_b_nz;
   assign w_ur       = a % w_b_nz;
   assign w_q_s      = (a[31] ^ b[31]) ? (32'd0 - w_sq) : w_sq;
   assign w_r_s      = a[31] ? (32'd0 - w_sr) : w_sr;

   always_comb begin
      w_res = 64'd0;
      case (op)
         MDU_MULT:  w_res = w_prod_s;
         MDU_MULTU: w_res = w_prod_u;
         MDU_DIV:   w_res = {w_r_s, w_q_s};
         MDU_DIVU:  w_res = {w_ur, w_uq};
         default:   w_res = 64'd0;
      endcase
      if (w_is_div && (b == 32'd0))
         w_res = {a, 32'hFFFF_FFFF};
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_commit    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = ST_RUN;
               w_cnt_nxt   = w_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            end
         end
         ST_RUN: begin
            if (clr) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == CW'(1)) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
               w_commit    = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - CW'(1);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_hi    <= 32'd0;
         r_lo    <= 32'd0;
         r_sh_hi <= 32'd0;
         r_sh_lo <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_accept) begin
            r_sh_hi <= w_res[63:32];
            r_sh_lo <= w_res[31:0];
         end else if (clr) begin
            r_sh_hi <= 32'd0;
            r_sh_lo <= 32'd0;
         end
         if (w_commit) begin
            r_hi <= r_sh_hi;
            r_lo <= r_sh_lo;
         end else begin
            if (w_mthi) r_hi <= a;
            if (w_mtlo) r_lo <= a;
         end
      end
   end

   assign busy      = (r_state == ST_RUN);
   assign hi        = r_hi;
   assign lo        = r_lo;
   assign mf_result = (mf_sel == MF_HI) ? r_hi :
                      (mf_sel == MF_LO) ? r_lo : 32'd0;

endmodule
